// File: rtl/cmp_mask_collector.sv
// cmp_mask_collector: consumer end of the compare-unit result stream.
// Packs result bit 0 of each valid beat into an MVL-wide mask seeded from
// old_mask (tail-undisturbed), commits it through a valid/ready write port and
// then pulses done for one cycle.
// Optional feature macro: CMP_COLLECT_MASK_EN -- when defined, beats whose
// element mask bit (res_in[DATA_WIDTH]) is 0 leave their mask bit undisturbed.
module cmp_mask_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int MVL        = 16,
  parameter int VLR_W      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  start,
  input  logic [VLR_W-1:0]      VLR,
  input  logic [MVL-1:0]        old_mask,
  input  logic [DATA_WIDTH+1:0] res_in,
  output logic                  busy,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [MVL-1:0]        wr_data,
  output logic                  done,
  output logic                  err
);

  // Element counter must hold the value MVL itself, so it is one bit wider
  // than the mask index when MVL is a power of two.
  localparam int CNT_W = $clog2(MVL + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [MVL-1:0]   acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             wr_valid_q, wr_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             beat_valid;
  logic             elem_active;
  logic [CNT_W-1:0] vlr_clip;

  assign beat_valid = res_in[DATA_WIDTH+1];

`ifdef CMP_COLLECT_MASK_EN
  assign elem_active = res_in[DATA_WIDTH];
  logic unused_res_bits;
  assign unused_res_bits = ^res_in[DATA_WIDTH-1:1];
`else
  // Element mask bit is ignored: every valid beat writes its mask bit.
  assign elem_active = 1'b1;
  logic unused_res_bits;
  assign unused_res_bits = ^res_in[DATA_WIDTH:1];
`endif

  // Requested element count clipped to the mask width.
  always_comb begin
    if (int'(VLR) > MVL) vlr_clip = CNT_W'(MVL);
    else                 vlr_clip = CNT_W'(VLR);
  end

  // Next-state and next-output logic for the IDLE -> COLLECT -> WRITE sequence.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    busy_d     = busy_q;
    wr_valid_d = wr_valid_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // A beat coinciding with start is dropped silently.
          n_d    = vlr_clip;
          acc_d  = old_mask;
          idx_d  = '0;
          busy_d = 1'b1;
          err_d  = 1'b0;
          if (vlr_clip == '0) begin
            state_d    = WRITE;
            wr_valid_d = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end else if (beat_valid) begin
          err_d = 1'b1;
        end
      end

      COLLECT: begin
        if (beat_valid) begin
          for (int i = 0; i < MVL; i++) begin
            if (i == int'(idx_q) && elem_active) acc_d[i] = res_in[0];
          end
          idx_d = idx_q + CNT_W'(1);
          if (idx_q + CNT_W'(1) == n_q) begin
            state_d    = WRITE;
            wr_valid_d = 1'b1;
          end
        end
      end

      WRITE: begin
        if (beat_valid) err_d = 1'b1;
        if (wr_ready) begin
          state_d    = IDLE;
          wr_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any vector in flight.
  always_ff @(posedge clk_i or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_data  = acc_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
